// File: rtl/s_term_ram_io_port.sv
// s_term_ram_io_port: south-terminal tile turning fabric requests into a sequenced single-port RAM channel.
module s_term_ram_io_port #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int CFG_FRAME       = 0,
    parameter int ADDR_W          = 10,
    parameter int DATA_W          = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int RD_LAT          = 2
) (
    input  logic                       UserCLK,
    input  logic                       UserRST,
    output logic                       UserCLKo,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
    input  logic                       req_valid,
    input  logic                       req_we,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    output logic                       req_ready,
    output logic                       rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       err,
    output logic                       ram_en,
    output logic                       ram_we,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic [DATA_W-1:0]          ram_wdata,
    input  logic [DATA_W-1:0]          ram_rdata
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int LW = $clog2(RD_LAT + 1);
    localparam int EW = 1 + ADDR_W + DATA_W;

    typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, RESP} state_t;

    state_t         state, state_nx;
    logic [3:0]     cfg;
    logic [EW-1:0]  fifo [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [LW-1:0]  lat_cnt;
    logic [EW-1:0]  head;
    logic           full, empty, accept, allowed, push, pop, lat_done;
    logic           unused_frame_bits;

    assign UserCLKo      = UserCLK;
    assign FrameStrobe_O = FrameStrobe;
    assign unused_frame_bits = ^FrameData[FrameBitsPerRow-1:4];

    assign full      = count == CW'(FIFO_DEPTH);
    assign empty     = count == '0;
    assign req_ready = cfg[0] & ~full;
    assign accept    = req_valid & req_ready;
    assign allowed   = req_we ? cfg[1] : cfg[2];
    assign push      = accept & allowed;
    assign head      = fifo[rd_ptr];
    // Writes chain straight out of WR so a queued burst issues one per cycle
    assign pop       = (state == IDLE || state == WR) && !empty;
    assign lat_done  = lat_cnt == LW'(RD_LAT);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, WR: state_nx = pop ? (head[EW-1] ? WR : RD) : IDLE;
            RD:       state_nx = RWAIT;
            RWAIT:    state_nx = lat_done ? RESP : RWAIT;
            RESP:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge UserCLK or posedge UserRST) begin
        if (UserRST) begin
            state     <= IDLE;
            cfg       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            lat_cnt   <= '0;
            err       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
        end else begin
            state <= state_nx;
            if (FrameStrobe[CFG_FRAME]) cfg <= FrameData[3:0];
            if (push) begin
                fifo[wr_ptr] <= {req_we, req_addr, req_wdata};
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count     <= count + CW'(push) - CW'(pop);
            err       <= accept & ~allowed;
            ram_en    <= pop;
            ram_we    <= pop & head[EW-1];
            if (pop) {ram_addr, ram_wdata} <= head[EW-2:0];
            // lat_cnt is 1 on the first RWAIT cycle, i.e. counts cycles since ram_en
            lat_cnt   <= (state == RWAIT) ? lat_cnt + LW'(1) : LW'(1);
            rsp_valid <= (state == RWAIT) && lat_done;
            if ((state == RWAIT) && lat_done) rsp_data <= ram_rdata;
            else if ((state == RESP) && !cfg[3]) rsp_data <= '0;
        end
    end
endmodule
